// File: rtl/dbg_pkg.sv
// Shared types and defaults for the debug-bus segment router.
// Contents: default address/index widths, segment identifiers, response error codes and
// router FSM states.
package dbg;

  localparam int unsigned Debug_addr_width          = 14;
  localparam int unsigned Debug_segment_index_width = 2;

  // Segment identifiers double as their segment index in the address MSBs.
  typedef enum logic [1:0] {
    SegCtl = 2'd0,
    SegRom = 2'd1,
    SegRam = 2'd2,
    SegIo  = 2'd3
  } seg_t;

  typedef enum logic [1:0] {
    ErrOk       = 2'd0,
    ErrUnmapped = 2'd1,
    ErrTimeout  = 2'd2
  } rsp_err_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } router_state_t;

endpackage

// File: rtl/dbg_seg_router_if.sv
// Host-side request/response handshake between the debug bridge and the segment router.
// Request: req_valid/req_ready, req_addr, req_we, req_wdata.
// Response: rsp_valid/rsp_ready, rsp_rdata, rsp_err.
// master = host bridge, slave = router.
interface dbg_seg_router_if
  import dbg::*;
#(
  parameter int unsigned ADDR_W = Debug_addr_width,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  rsp_err_t          rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dbg_seg_router_ctr.sv
// Wait-cycle counter for the segment router (module dbg_timeout_ctr).
// Ports: clk_i, rst_ni (sync, active-low), clr_i (clear, dominant), en_i (count),
// tc_o (high in the cycle the count reaches TIMEOUT).
module dbg_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned CtrW = $clog2(TIMEOUT + 1);
  // Count starts at 0 in the first wait cycle, so the TIMEOUT-th cycle holds TIMEOUT-1.
  localparam logic [CtrW-1:0] TcVal = CtrW'(TIMEOUT - 1);

  logic [CtrW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tc_o = en_i && !clr_i && (cnt_q == TcVal);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dbg_seg_router.sv
// Debug-bus segment router: decodes the address MSBs and forwards a single-beat request to one
// of N_SEG targets over a level req / single-cycle ack handshake, then returns data + error.
// Ports: clk_i, rst_ni (sync, active-low), bus (host handshake, slave modport),
// seg_req_o (one-hot), seg_we_o, seg_addr_o, seg_wdata_o (shared), seg_ack_i, seg_rdata_i
// (segment i at [i*DATA_W +: DATA_W]), busy_o.
// Optional: define DBG_ROUTER_ERRLOG_EN to add err_addr_o / err_cnt_o (last failing address
// and saturating error count).
module dbg_seg_router
  import dbg::*;
#(
  parameter int unsigned       ADDR_W      = Debug_addr_width,
  parameter int unsigned       SEG_IDX_W   = Debug_segment_index_width,
  parameter int unsigned       N_SEG       = 4,
  parameter logic [N_SEG-1:0]  SEG_EN_MASK = {N_SEG{1'b1}},
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  dbg_seg_router_if.slave           bus,
  output logic [N_SEG-1:0]          seg_req_o,
  output logic                      seg_we_o,
  output logic [ADDR_W-SEG_IDX_W-1:0] seg_addr_o,
  output logic [DATA_W-1:0]         seg_wdata_o,
  input  logic [N_SEG-1:0]          seg_ack_i,
  input  logic [N_SEG*DATA_W-1:0]   seg_rdata_i,
`ifdef DBG_ROUTER_ERRLOG_EN
  output logic [ADDR_W-1:0]         err_addr_o,
  output logic [7:0]                err_cnt_o,
`endif
  output logic                      busy_o
);
  localparam int unsigned SegAddrW = ADDR_W - SEG_IDX_W;

  router_state_t         state_q, state_d;
  logic [N_SEG-1:0]      seg_req_q, seg_req_d;
  logic                  seg_we_q, seg_we_d;
  logic [SegAddrW-1:0]   seg_addr_q, seg_addr_d;
  logic [DATA_W-1:0]     seg_wdata_q, seg_wdata_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  rsp_err_t              rsp_err_q, rsp_err_d;

  logic [SEG_IDX_W-1:0]  idx;
  logic [N_SEG-1:0]      sel_onehot;
  logic                  ack_hit;
  logic [DATA_W-1:0]     ack_rdata;
  logic                  tc;
  logic                  err_evt;

  assign idx = bus.req_addr[ADDR_W-1 -: SEG_IDX_W];

  // Empty one-hot means unmapped: index beyond N_SEG or segment masked off.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < N_SEG; i++) begin
      if ((idx == SEG_IDX_W'(i)) && SEG_EN_MASK[i]) sel_onehot[i] = 1'b1;
    end
  end

  // Only the ack of the segment being requested counts.
  assign ack_hit = |(seg_ack_i & seg_req_q);

  always_comb begin
    ack_rdata = '0;
    for (int unsigned i = 0; i < N_SEG; i++) begin
      if (seg_req_q[i]) ack_rdata = seg_rdata_i[i*DATA_W +: DATA_W];
    end
  end

  dbg_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q != StWait),
    .en_i   (state_q == StWait),
    .tc_o   (tc)
  );

  always_comb begin
    state_d     = state_q;
    seg_req_d   = seg_req_q;
    seg_we_d    = seg_we_q;
    seg_addr_d  = seg_addr_q;
    seg_wdata_d = seg_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_evt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          seg_we_d    = bus.req_we;
          seg_addr_d  = bus.req_addr[SegAddrW-1:0];
          seg_wdata_d = bus.req_wdata;
          if (|sel_onehot) begin
            state_d   = StWait;
            seg_req_d = sel_onehot;
          end else begin
            state_d     = StResp;
            rsp_err_d   = ErrUnmapped;
            rsp_rdata_d = '0;
            err_evt     = 1'b1;
          end
        end
      end
      StWait: begin
        // Ack is tested first so it wins over a coincident terminal count.
        if (ack_hit) begin
          state_d     = StResp;
          seg_req_d   = '0;
          rsp_err_d   = ErrOk;
          rsp_rdata_d = seg_we_q ? '0 : ack_rdata;
        end else if (tc) begin
          state_d     = StResp;
          seg_req_d   = '0;
          rsp_err_d   = ErrTimeout;
          rsp_rdata_d = '1;
          err_evt     = 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      seg_req_q   <= '0;
      seg_we_q    <= 1'b0;
      seg_addr_q  <= '0;
      seg_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ErrOk;
    end else begin
      state_q     <= state_d;
      seg_req_q   <= seg_req_d;
      seg_we_q    <= seg_we_d;
      seg_addr_q  <= seg_addr_d;
      seg_wdata_q <= seg_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef DBG_ROUTER_ERRLOG_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  always_comb begin
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if ((state_q == StIdle) && bus.req_valid) addr_d = bus.req_addr;
    if (err_evt) begin
      // Unmapped errors occur in the accept cycle, before addr_q is loaded.
      err_addr_d = (state_q == StIdle) ? bus.req_addr : addr_q;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign seg_req_o     = seg_req_q;
  assign seg_we_o      = seg_we_q;
  assign seg_addr_o    = seg_addr_q;
  assign seg_wdata_o   = seg_wdata_q;
  assign busy_o        = (state_q != StIdle);
endmodule

// File: tb/tb_dbg_seg_router.sv
// Directed bench for dbg_seg_router: N_SEG=3, TIMEOUT=8. Inputs driven and outputs sampled on
// the falling clock edge; cycle 1 is the first cycle after the accepting rising edge.
module tb_dbg_seg_router;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  seg_req;
  logic        seg_we;
  logic [11:0] seg_addr;
  logic [7:0]  seg_wdata;
  logic [2:0]  seg_ack;
  logic [23:0] seg_rdata;
  logic        busy;
`ifdef DBG_ROUTER_ERRLOG_EN
  logic [13:0] err_addr;
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_seg_router_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  dbg_seg_router #(
    .ADDR_W    (14),
    .SEG_IDX_W (2),
    .N_SEG     (3),
    .DATA_W    (8),
    .TIMEOUT   (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .seg_req_o   (seg_req),
    .seg_we_o    (seg_we),
    .seg_addr_o  (seg_addr),
    .seg_wdata_o (seg_wdata),
    .seg_ack_i   (seg_ack),
    .seg_rdata_i (seg_rdata),
`ifdef DBG_ROUTER_ERRLOG_EN
    .err_addr_o  (err_addr),
    .err_cnt_o   (err_cnt),
`endif
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a request in an IDLE cycle; returns at the sample point of cycle 1.
  task automatic issue(input logic [13:0] a, input logic we, input logic [7:0] wd);
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    chk({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
    chk({tag, "_seg_req"},   32'(seg_req), 0);
    chk({tag, "_seg_we"},    32'(seg_we), 0);
    chk({tag, "_seg_addr"},  32'(seg_addr), 0);
    chk({tag, "_seg_wdata"}, 32'(seg_wdata), 0);
    chk({tag, "_busy"},      32'(busy), 0);
`ifdef DBG_ROUTER_ERRLOG_EN
    chk({tag, "_err_addr"},  32'(err_addr), 0);
    chk({tag, "_err_cnt"},   32'(err_cnt), 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    seg_ack       = '0;
    seg_rdata     = {8'h22, 8'hA5, 8'h11};
    repeat (2) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Read ROM, ack 3 cycles after seg_req appears.
    issue(14'h1005, 1'b0, 8'h00);
    chk("rom_seg_req", 32'(seg_req), 3'b010);
    chk("rom_seg_addr", 32'(seg_addr), 12'h005);
    chk("rom_seg_we", 32'(seg_we), 0);
    chk("rom_busy", 32'(busy), 1);
    chk("rom_req_ready", 32'(bus.req_ready), 0);
    repeat (3) step();
    chk("rom_no_rsp_c4", 32'(bus.rsp_valid), 0);
    seg_ack = 3'b010;
    step();
    seg_ack = '0;
    chk("rom_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rom_rdata", 32'(bus.rsp_rdata), 8'hA5);
    chk("rom_err", 32'(bus.rsp_err), 0);
    chk("rom_seg_req_drop", 32'(seg_req), 0);
    step();
    chk("rom_idle_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rom_idle_seg_addr_held", 32'(seg_addr), 12'h005);

    // Write RAM, ack in cycle 1.
    issue(14'h2010, 1'b1, 8'h3C);
    chk("ram_seg_req", 32'(seg_req), 3'b100);
    chk("ram_seg_we", 32'(seg_we), 1);
    chk("ram_seg_wdata", 32'(seg_wdata), 8'h3C);
    chk("ram_seg_addr", 32'(seg_addr), 12'h010);
    seg_ack = 3'b100;
    step();
    seg_ack = '0;
    chk("ram_rsp_valid_c2", 32'(bus.rsp_valid), 1);
    chk("ram_rdata_zero", 32'(bus.rsp_rdata), 0);
    chk("ram_err", 32'(bus.rsp_err), 0);
    step();

    // Unmapped index 3 (N_SEG=3).
    issue(14'h3000, 1'b0, 8'h00);
    chk("unm_seg_req", 32'(seg_req), 0);
    chk("unm_rsp_valid_c1", 32'(bus.rsp_valid), 1);
    chk("unm_err", 32'(bus.rsp_err), 1);
    chk("unm_rdata", 32'(bus.rsp_rdata), 0);
`ifdef DBG_ROUTER_ERRLOG_EN
    chk("unm_err_addr", 32'(err_addr), 14'h3000);
    chk("unm_err_cnt", 32'(err_cnt), 1);
`endif
    step();

    // CTL never acks; a stray ROM ack in cycle 3 must be ignored.
    issue(14'h0ABC, 1'b0, 8'h00);
    chk("to_seg_req", 32'(seg_req), 3'b001);
    repeat (2) step();
    seg_ack = 3'b010;
    step();
    seg_ack = '0;
    repeat (4) step();
    chk("to_no_rsp_c8", 32'(bus.rsp_valid), 0);
    chk("to_seg_req_c8", 32'(seg_req), 3'b001);
    step();
    chk("to_rsp_valid_c9", 32'(bus.rsp_valid), 1);
    chk("to_rdata", 32'(bus.rsp_rdata), 8'hFF);
    chk("to_err", 32'(bus.rsp_err), 2);
    chk("to_seg_req_drop", 32'(seg_req), 0);
`ifdef DBG_ROUTER_ERRLOG_EN
    chk("to_err_addr", 32'(err_addr), 14'h0ABC);
    chk("to_err_cnt", 32'(err_cnt), 2);
`endif
    step();

    // Ack in the terminal-count cycle wins.
    issue(14'h0ABC, 1'b0, 8'h00);
    repeat (7) step();
    chk("tc_no_rsp_c8", 32'(bus.rsp_valid), 0);
    seg_ack = 3'b001;
    step();
    seg_ack = '0;
    chk("tc_rsp_valid_c9", 32'(bus.rsp_valid), 1);
    chk("tc_err_ok", 32'(bus.rsp_err), 0);
    chk("tc_rdata", 32'(bus.rsp_rdata), 8'h11);
`ifdef DBG_ROUTER_ERRLOG_EN
    chk("tc_err_cnt_unchanged", 32'(err_cnt), 2);
`endif
    step();

    // Response back-pressure for 5 cycles with a competing request pending.
    bus.rsp_ready = 1'b0;
    issue(14'h1007, 1'b0, 8'h00);
    seg_ack = 3'b010;
    step();
    seg_ack = '0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 14'h2001;
    bus.req_we    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rdata", 32'(bus.rsp_rdata), 8'hA5);
      chk("bp_err", 32'(bus.rsp_err), 0);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_seg_addr_held", 32'(seg_addr), 12'h007);
      if (k < 4) step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_after_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("bp_after_req_ready", 32'(bus.req_ready), 1);
    chk("bp_after_seg_req", 32'(seg_req), 0);
    step();
    bus.req_valid = 1'b0;
    chk("bp_new_seg_req", 32'(seg_req), 3'b100);
    chk("bp_new_seg_addr", 32'(seg_addr), 12'h001);
    seg_ack = 3'b100;
    step();
    seg_ack = '0;
    chk("bp_new_rdata", 32'(bus.rsp_rdata), 8'h22);
    step();

    // Reset while waiting: aborts, late ack ignored, no response.
    issue(14'h1001, 1'b0, 8'h00);
    chk("rw_busy", 32'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_vals("rw");
    seg_ack = 3'b010;
    step();
    seg_ack = '0;
    chk("rw_late_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rw_late_busy", 32'(busy), 0);
    chk("rw_late_seg_req", 32'(seg_req), 0);
    step();
    chk("rw_late_rsp_valid2", 32'(bus.rsp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbg_seg_router.md
Name: dbg_seg_router

Overview:
- Parametrised debug-bus segment router.
- Accepts single-beat read/write requests from the host debug bridge over a valid/ready handshake.
- Decodes the top segment-index bits of the address and forwards the request to one of N_SEG segment targets (CTL, ROM, RAM, IO, plus any additional segments) over a req/ack handshake.
- Returns data and an error code: OK, UNMAPPED or TIMEOUT.

Parameters:
- ADDR_W, 14, full debug address width.
- SEG_IDX_W, 2, segment index width (address MSBs).
- N_SEG, 4, number of implemented segments; must satisfy 1 <= N_SEG <= 2**SEG_IDX_W.
- SEG_EN_MASK, {N_SEG{1'b1}}, per-segment enable; a cleared bit makes that segment UNMAPPED.
- DATA_W, 8, data width.
- TIMEOUT, 255, maximum cycles spent waiting for ack; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  host request valid.
- req_ready  out  1  router can accept a request.
- req_addr  in  ADDR_W  {segment index, segment address}.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  2  dbg::rsp_err_t code.
- seg_req  out  N_SEG  one-hot request, level, held until ack.
- seg_we  out  1  shared write enable.
- seg_addr  out  ADDR_W-SEG_IDX_W  shared segment-local address.
- seg_wdata  out  DATA_W  shared write data.
- seg_ack  in  N_SEG  per-segment single-cycle acknowledge.
- seg_rdata  in  N_SEG*DATA_W  per-segment read data; segment i occupies bits [i*DATA_W +: DATA_W].
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=OK, seg_req=0, seg_we=0, seg_addr=0, seg_wdata=0, busy=0, timeout counter=0.
- Reset applied mid-transaction aborts it immediately. An outstanding seg_req drops the following cycle and no response is produced.
- FSM IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register we, addr and wdata into the seg_* outputs.
  - If idx < N_SEG and SEG_EN_MASK[idx]=1: go to WAIT with seg_req[idx]=1.
  - Otherwise: go to RESP with err=UNMAPPED, rdata=0, and no seg_req pulse.
- FSM WAIT:
  - req_ready=0; the counter increments every cycle.
  - seg_ack[idx]=1: capture seg_rdata slice idx (reads only; writes return 0), clear seg_req, go to RESP with err=OK.
  - Acks from any other segment are ignored.
  - When the counter reaches TIMEOUT with no ack: clear seg_req, go to RESP with err=TIMEOUT and rdata all ones.
  - An ack arriving in the terminal-count cycle wins, giving OK.
- FSM RESP:
  - rsp_valid=1; rdata and err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid=0, counter=0, go to IDLE.
  - req_ready stays 0 until IDLE, so there is no overlap; one transaction is in flight at most.
- Latency (accept edge = cycle 0):
  - seg_req is visible in cycle 1.
  - A same-cycle ack in cycle 1 gives rsp_valid in cycle 2; minimum mapped latency is 2 cycles.
  - UNMAPPED gives rsp_valid in cycle 1.
  - TIMEOUT gives rsp_valid in cycle TIMEOUT+1.
- Targets must not ack while their seg_req is low. Such acks are ignored in every state.
- seg_addr, seg_we and seg_wdata hold their last values after completion; they change only on acceptance.

Optional Feature:
- DBG_ROUTER_ERRLOG_EN defined:
  - Adds outputs err_addr (ADDR_W) and err_cnt (8).
  - On each entry to RESP with err != OK, err_addr latches the request address and err_cnt increments, saturating at 255.
  - Both reset to 0.
- DBG_ROUTER_ERRLOG_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dbg additions:
  - rsp_err_t enum, 2 bits: OK=0, UNMAPPED=1, TIMEOUT=2.
  - router_state_t enum: IDLE, WAIT, RESP.
  - Debug_addr_width and Debug_segment_index_width remain the defaults for ADDR_W and SEG_IDX_W.
  - Existing CTL/ROM/RAM/IO seg_t values map to segment indices 0-3.
- Sub-module dbg_timeout_ctr: clear/enable inputs, terminal-count output, parameter TIMEOUT, width $clog2(TIMEOUT+1).

Test Plan:
- Read ROM (req_addr=14'h1005, we=0), ROM acks 3 cycles after seg_req with rdata 8'hA5 -> seg_req=4'b0010, seg_addr=12'h005; rsp_rdata=8'hA5, rsp_err=OK.
- Write RAM (req_addr=14'h2010, wdata=8'h3C), ack in cycle 1 -> seg_we=1, seg_wdata=8'h3C; rsp_valid in cycle 2, rsp_rdata=0, rsp_err=OK.
- N_SEG=3, req_addr=14'h3000 -> no seg_req pulse; rsp_valid in cycle 1, rsp_err=UNMAPPED. With DBG_ROUTER_ERRLOG_EN: err_addr=14'h3000, err_cnt=1.
- TIMEOUT=8, CTL never acks -> seg_req drops; rsp_valid in cycle 9, rsp_rdata=8'hFF, rsp_err=TIMEOUT. Repeat with an ack in cycle 8 -> rsp_err=OK.
- rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; a new req_valid is not accepted until the cycle after the handshake.
- rst_n low for one cycle while in WAIT -> all outputs return to reset values; a late ack is ignored; no response is produced.
